// File: rtl/rect_fill_engine.sv
// Solid-rectangle fill engine: clips one command to the frame buffer and streams
// one pixel write per cycle in row-major order. RECT_FILL_OUTLINE_EN adds outline-only drawing.
module rect_fill_engine #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int ADDR_W    = 17,
  parameter int COLOR_W   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [8:0]         cmd_x,
  input  logic [7:0]         cmd_y,
  input  logic [8:0]         cmd_w,
  input  logic [8:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
`ifdef RECT_FILL_OUTLINE_EN
  input  logic               cmd_outline,
`endif
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_write_addr,
  output logic [COLOR_W-1:0] fb_write_data,
  input  logic               fb_write_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [9:0]        FB_W10 = 10'(FB_WIDTH);
  localparam logic [9:0]        FB_H10 = 10'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_WIDTH);

  logic [1:0]         state_q, state_d;
  logic [8:0]         col_q, col_d, x_start_q, x_start_d;
  logic [7:0]         row_q, row_d;
  logic [9:0]         x_end_q, x_end_d, y_end_q, y_end_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d, addr_q, addr_d;
  logic [COLOR_W-1:0] color_q, color_d, data_q, data_d;
  logic               fb_we_q, fb_we_d, busy_q, busy_d, done_q, done_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [9:0]         sum_x, sum_y, col_inc, row_inc;
  logic               cmd_empty, draw;
`ifdef RECT_FILL_OUTLINE_EN
  logic               outline_q, outline_d;
  logic [7:0]         y_start_q, y_start_d;
  logic [9:0]         x_right_q, x_right_d, y_bot_q, y_bot_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    x_start_d  = x_start_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    color_d    = color_q;
`ifdef RECT_FILL_OUTLINE_EN
    outline_d  = outline_q;
    y_start_d  = y_start_q;
    x_right_d  = x_right_q;
    y_bot_d    = y_bot_q;
`endif
    // 10-bit sums so x+w and y+h never wrap before clipping
    sum_x     = {1'b0, cmd_x} + {1'b0, cmd_w};
    sum_y     = {2'b00, cmd_y} + {1'b0, cmd_h};
    cmd_empty = (cmd_w == 9'd0) || (cmd_h == 9'd0) ||
                ({1'b0, cmd_x} >= FB_W10) || ({2'b00, cmd_y} >= FB_H10);
    col_inc   = {1'b0, col_q} + 10'd1;
    row_inc   = {2'b00, row_q} + 10'd1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          color_d    = cmd_color;
          x_start_d  = cmd_x;
          col_d      = cmd_x;
          row_d      = cmd_y;
          row_base_d = ADDR_W'(cmd_y) * FB_W_A;
          x_end_d    = (sum_x > FB_W10) ? FB_W10 : sum_x;
          y_end_d    = (sum_y > FB_H10) ? FB_H10 : sum_y;
`ifdef RECT_FILL_OUTLINE_EN
          outline_d  = cmd_outline;
          y_start_d  = cmd_y;
          x_right_d  = sum_x - 10'd1;
          y_bot_d    = sum_y - 10'd1;
`endif
          state_d    = cmd_empty ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        // Skipped (fb_we=0) pixels advance without waiting on the buffer port
        if (fb_write_ready || !fb_we_q) begin
          if (col_inc == x_end_q) begin
            if (row_inc == y_end_q) begin
              state_d = S_DONE;
            end else begin
              col_d      = x_start_q;
              row_d      = row_q + 8'd1;
              row_base_d = row_base_q + FB_W_A;
            end
          end else begin
            col_d = col_q + 9'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef RECT_FILL_OUTLINE_EN
    draw = !outline_d || (col_d == x_start_d) || ({1'b0, col_d} == x_right_d) ||
           (row_d == y_start_d) || ({2'b00, row_d} == y_bot_d);
`else
    draw = 1'b1;
`endif

    fb_we_d     = (state_d == S_FILL) && draw;
    addr_d      = row_base_d + ADDR_W'(col_d);
    data_d      = color_d;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_q == S_DONE);
    cmd_ready_d = (state_d == S_IDLE) && (state_q != S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      x_start_q   <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      color_q     <= '0;
      fb_we_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
`ifdef RECT_FILL_OUTLINE_EN
      outline_q   <= 1'b0;
      y_start_q   <= '0;
      x_right_q   <= '0;
      y_bot_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      x_start_q   <= x_start_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      color_q     <= color_d;
      fb_we_q     <= fb_we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef RECT_FILL_OUTLINE_EN
      outline_q   <= outline_d;
      y_start_q   <= y_start_d;
      x_right_q   <= x_right_d;
      y_bot_q     <= y_bot_d;
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign fb_we         = fb_we_q;
  assign fb_write_addr = addr_q;
  assign fb_write_data = data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
